// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem requests, prefetch FIFO, ID output register.
// Optional IF_PERF_CNT_EN adds bubble/redirect performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        hdu_stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SumW  = CntW + 1;
  localparam int unsigned DiscW = 16;

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]  in_flight_q, in_flight_d;
  logic [DiscW-1:0] discard_cnt_q, discard_cnt_d;

  // Prefetch FIFO storage and pointers
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]  fifo_wr_q, fifo_wr_d;
  logic [PtrW-1:0]  fifo_rd_q, fifo_rd_d;
  logic [CntW-1:0]  fifo_cnt_q, fifo_cnt_d;

  // PC tags of requests still owed a response (non-discarded only)
  logic [31:0]      tag_q [FIFO_DEPTH];
  logic [PtrW-1:0]  tag_wr_q, tag_wr_d;
  logic [PtrW-1:0]  tag_rd_q, tag_rd_d;

  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_pc4_q, id_pc4_d;

  logic             fetching;
  logic             credit_ok;
  logic             req_fire;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [SumW-1:0]  occupancy;

  assign fetching   = (state_q == StRun) || (state_q == StDrain);
  assign occupancy  = SumW'(in_flight_q) + SumW'(fifo_cnt_q);
  assign credit_ok  = occupancy < SumW'(FIFO_DEPTH);
  assign fifo_empty = (fifo_cnt_q == '0);

  assign imem_req_valid = fetching && credit_ok && !redirect_en;
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (discard_cnt_q != '0);
  assign rsp_keep = imem_rsp_valid && (discard_cnt_q == '0);
  assign fifo_pop = !redirect_en && !hdu_stall && !fifo_empty;

  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign id_pc4   = id_pc4_q;

  // Fetch PC, credit and discard bookkeeping
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    in_flight_d   = in_flight_q;
    discard_cnt_d = discard_cnt_q;

    if (rsp_drop) begin
      discard_cnt_d = discard_cnt_q - DiscW'(1);
    end

    if (redirect_en) begin
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      in_flight_d   = '0;
      // Every outstanding non-discarded request becomes stale, less one answered right now
      discard_cnt_d = discard_cnt_d + DiscW'(in_flight_q) - DiscW'(rsp_keep);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      in_flight_d = in_flight_q + CntW'(req_fire) - CntW'(rsp_keep);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun,
      StDrain: state_d = (discard_cnt_d != '0) ? StDrain : StRun;
      default: state_d = StBoot;
    endcase
  end

  // FIFO and tag-queue pointers
  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;

    if (redirect_en) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
    end else begin
      if (rsp_keep) begin
        fifo_wr_d = fifo_wr_q + PtrW'(1);
        tag_rd_d  = tag_rd_q + PtrW'(1);
      end
      if (fifo_pop) begin
        fifo_rd_d = fifo_rd_q + PtrW'(1);
      end
      if (req_fire) begin
        tag_wr_d = tag_wr_q + PtrW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CntW'(rsp_keep) - CntW'(fifo_pop);
    end
  end

  // ID output register; redirect beats stall
  always_comb begin
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;

    if (redirect_en) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (hdu_stall) begin
      id_valid_d = id_valid_q;
    end else if (!fifo_empty) begin
      id_valid_d = 1'b1;
      id_inst_d  = fifo_inst_q[fifo_rd_q];
      id_pc_d    = fifo_pc_q[fifo_rd_q];
      id_pc4_d   = fifo_pc_q[fifo_rd_q] + 32'd4;
    end else begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      in_flight_q   <= '0;
      discard_cnt_q <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      in_flight_q   <= in_flight_d;
      discard_cnt_q <= discard_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
    end
  end

  // Storage arrays need no reset; pointers qualify their contents
  always_ff @(posedge clk) begin
    if (!rst && !redirect_en) begin
      if (req_fire) begin
        tag_q[tag_wr_q] <= fetch_pc_q;
      end
      if (rsp_keep) begin
        fifo_inst_q[fifo_wr_q] <= imem_rsp_data;
        fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubble_q;
  logic [31:0] perf_redirect_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_q   <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (!id_valid_q && (state_q != StBoot)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
      if (redirect_en) begin
        perf_redirect_q <= perf_redirect_q + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt   = perf_bubble_q;
  assign perf_redirect_cnt = perf_redirect_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory broke the protocol
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (in_flight_q == '0) && (discard_cnt_q == '0)))
    else $error("if_fetch_unit: imem response with no request outstanding");

  a_addr_hold: assert property (@(posedge clk) disable iff (rst)
    (imem_req_valid && !imem_req_ready && !redirect_en) |=> $stable(imem_req_addr))
    else $error("if_fetch_unit: request address changed while waiting for ready");
`endif

endmodule
